// File: rtl/data_memory_unit_if.sv
// Data-port bus between the EX/MEM stage (master) and the data memory unit (slave).
// The master holds en/we/addr/wd stable while stall is high.
`timescale 1ns/1ps

interface data_memory_unit_if;
    logic        en;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wd;
    logic        stall;
    logic [31:0] rd;

    modport master (
        output en,
        output we,
        output addr,
        output wd,
        input  stall,
        input  rd
    );

    modport slave (
        input  en,
        input  we,
        input  addr,
        input  wd,
        output stall,
        output rd
    );
endinterface

// File: rtl/data_memory_unit.sv
// Data-side memory slave: word-addressed block RAM with a one-cycle load stall,
// plus an MMIO window (addr[31]=1) mapping onto byte TX/RX FIFOs for the serial link.
// Side effects commit only on edges where the pipeline advances (pipe_hold=0).
// Optional build macro DMEM_FAULT_EN: out-of-range RAM accesses are trapped
// (stores dropped, loads return 32'hDEADBEEF) and flagged on a sticky fault output.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | no RAM read outstanding; a RAM load here stalls and issues
// LOAD_WAIT | RAM output register holds load data; rd valid, stall low
`timescale 1ns/1ps

module data_memory_unit #(
    parameter int DEPTH_LOG2   = 16,
    parameter int TX_FIFO_LOG2 = 4,
    parameter int RX_FIFO_LOG2 = 4
) (
    input  logic              clock,
    input  logic              reset,
    data_memory_unit_if.slave m_data,
    input  logic              pipe_hold,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready
`ifdef DMEM_FAULT_EN
    ,
    output logic              fault
`endif
);

    localparam int RAM_WORDS = 1 << DEPTH_LOG2;
    localparam int TX_DEPTH  = 1 << TX_FIFO_LOG2;
    localparam int RX_DEPTH  = 1 << RX_FIFO_LOG2;

    localparam logic [TX_FIFO_LOG2-1:0] TX_PTR_ONE = TX_FIFO_LOG2'(1);
    localparam logic [TX_FIFO_LOG2:0]   TX_CNT_ONE = (TX_FIFO_LOG2 + 1)'(1);
    localparam logic [RX_FIFO_LOG2-1:0] RX_PTR_ONE = RX_FIFO_LOG2'(1);
    localparam logic [RX_FIFO_LOG2:0]   RX_CNT_ONE = (RX_FIFO_LOG2 + 1)'(1);

    typedef enum logic [0:0] {
        IDLE      = 1'b0,
        LOAD_WAIT = 1'b1
    } state_t;

    state_t state;

    // RAM storage and its synchronous output register
    logic [31:0] mem [RAM_WORDS];
    logic [31:0] ram_q;

    // FIFO storage, pointers and occupancy
    logic [7:0]              tx_buf [TX_DEPTH];
    logic [TX_FIFO_LOG2-1:0] tx_wr_ptr;
    logic [TX_FIFO_LOG2-1:0] tx_rd_ptr;
    logic [TX_FIFO_LOG2:0]   tx_count;
    logic [7:0]              rx_buf [RX_DEPTH];
    logic [RX_FIFO_LOG2-1:0] rx_wr_ptr;
    logic [RX_FIFO_LOG2-1:0] rx_rd_ptr;
    logic [RX_FIFO_LOG2:0]   rx_count;

    // Request decode
    logic                  is_mmio;
    logic [1:0]            mmio_off;
    logic [DEPTH_LOG2-1:0] ram_idx;
    logic                  ram_oor;
    logic                  ram_load;
    logic                  ram_store;
    logic                  tx_store;
    logic                  rx_load;

    // FIFO status and transfer strobes
    logic tx_full;
    logic tx_empty;
    logic rx_full;
    logic rx_empty;
    logic tx_push;
    logic tx_pop;
    logic rx_push;
    logic rx_pop;
    logic ram_we;
    logic ram_issue;
    logic stall_int;
    logic [31:0] rd_mux;

    assign is_mmio  = m_data.addr[31];
    assign mmio_off = m_data.addr[1:0];
    assign ram_idx  = m_data.addr[DEPTH_LOG2-1:0];

`ifdef DMEM_FAULT_EN
    // Any nonzero bit between the RAM index and the MMIO select is out of range.
    assign ram_oor = ((m_data.addr[30:0] >> DEPTH_LOG2) != '0);
`else
    // Upper index bits are ignored, so RAM addresses simply wrap.
    logic unused_addr_hi;
    assign unused_addr_hi = ^m_data.addr[30:DEPTH_LOG2];
    assign ram_oor        = 1'b0;
`endif

    assign ram_load  = m_data.en & ~m_data.we & ~is_mmio;
    assign ram_store = m_data.en &  m_data.we & ~is_mmio;
    assign tx_store  = m_data.en &  m_data.we &  is_mmio & (mmio_off == 2'd0);
    assign rx_load   = m_data.en & ~m_data.we &  is_mmio & (mmio_off == 2'd1);

    // Fullness comes from the MSB of the occupancy counter, which only reaches
    // the depth value when the FIFO is full.
    assign tx_full  = tx_count[TX_FIFO_LOG2];
    assign tx_empty = (tx_count == '0);
    assign rx_full  = rx_count[RX_FIFO_LOG2];
    assign rx_empty = (rx_count == '0);

    // A TX store into a full FIFO stalls on registered fullness only: a pop on
    // the same edge frees a slot but the store waits one more cycle.
    assign stall_int = ((state == IDLE) & ram_load) | (tx_store & tx_full);

    assign ram_issue = (state == IDLE) & ram_load;
    assign ram_we    = ram_store & ~pipe_hold & ~ram_oor;
    assign tx_push   = tx_store & ~tx_full & ~pipe_hold;
    assign tx_pop    = ~tx_empty & tx_ready;
    assign rx_push   = rx_valid & ~rx_full;
    assign rx_pop    = rx_load & ~rx_empty & ~stall_int & ~pipe_hold;

    assign m_data.stall = stall_int;
    assign m_data.rd    = rd_mux;
    assign tx_data      = tx_buf[tx_rd_ptr];
    assign tx_valid     = ~tx_empty;
    assign rx_ready     = ~rx_full;

    // Load data mux: RAM result only in LOAD_WAIT, MMIO reads straight from FIFO state.
    always_comb begin
        rd_mux = '0;
        if (m_data.en && !m_data.we) begin
            if (!is_mmio) begin
                if (state == LOAD_WAIT) begin
                    rd_mux = ram_oor ? 32'hDEADBEEF : ram_q;
                end
            end else begin
                unique case (mmio_off)
                    2'd1: begin
                        if (!rx_empty) begin
                            rd_mux = {24'b0, rx_buf[rx_rd_ptr]};
                        end
                    end
                    2'd2:    rd_mux = {30'b0, ~rx_empty, ~tx_full};
                    default: rd_mux = '0;
                endcase
            end
        end
    end

    // Load sequencer: one stall cycle to issue, then hold the result while the pipe is held.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            unique case (state)
                IDLE: begin
                    if (ram_load) begin
                        state <= LOAD_WAIT;
                    end
                end
                LOAD_WAIT: begin
                    if (!pipe_hold) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Block RAM: registered read on issue only, so ram_q holds through LOAD_WAIT; contents survive reset.
    always_ff @(posedge clock) begin
        if (ram_issue) begin
            ram_q <= mem[ram_idx];
        end
        if (ram_we) begin
            mem[ram_idx] <= m_data.wd;
        end
    end

    // FIFO payload storage, written at the write pointer on each push.
    always_ff @(posedge clock) begin
        if (tx_push) begin
            tx_buf[tx_wr_ptr] <= m_data.wd[7:0];
        end
        if (rx_push) begin
            rx_buf[rx_wr_ptr] <= rx_data;
        end
    end

    // TX FIFO pointers and occupancy; push and pop together leave the count unchanged.
    always_ff @(posedge clock) begin
        if (reset) begin
            tx_wr_ptr <= '0;
            tx_rd_ptr <= '0;
            tx_count  <= '0;
        end else begin
            if (tx_push) begin
                tx_wr_ptr <= tx_wr_ptr + TX_PTR_ONE;
            end
            if (tx_pop) begin
                tx_rd_ptr <= tx_rd_ptr + TX_PTR_ONE;
            end
            unique case ({tx_push, tx_pop})
                2'b10:   tx_count <= tx_count + TX_CNT_ONE;
                2'b01:   tx_count <= tx_count - TX_CNT_ONE;
                default: tx_count <= tx_count;
            endcase
        end
    end

    // RX FIFO pointers and occupancy; push and pop together leave the count unchanged.
    always_ff @(posedge clock) begin
        if (reset) begin
            rx_wr_ptr <= '0;
            rx_rd_ptr <= '0;
            rx_count  <= '0;
        end else begin
            if (rx_push) begin
                rx_wr_ptr <= rx_wr_ptr + RX_PTR_ONE;
            end
            if (rx_pop) begin
                rx_rd_ptr <= rx_rd_ptr + RX_PTR_ONE;
            end
            unique case ({rx_push, rx_pop})
                2'b10:   rx_count <= rx_count + RX_CNT_ONE;
                2'b01:   rx_count <= rx_count - RX_CNT_ONE;
                default: rx_count <= rx_count;
            endcase
        end
    end

`ifdef DMEM_FAULT_EN
    // Sticky fault on the edge an out-of-range RAM access commits: stores
    // immediately, loads when they leave LOAD_WAIT.
    always_ff @(posedge clock) begin
        if (reset) begin
            fault <= 1'b0;
        end else if (!pipe_hold && ram_oor &&
                     (ram_store || (ram_load && state == LOAD_WAIT))) begin
            fault <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_data_memory_unit.sv
// Directed bench for data_memory_unit: a queue/array model checked every cycle,
// plus literal expectations along the stimulus that pin the model.
`timescale 1ns/1ps

module tb_data_memory_unit;

    logic       clock;
    logic       reset;
    logic       pipe_hold;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
`ifdef DMEM_FAULT_EN
    logic       fault;
`endif

    data_memory_unit_if m_data ();

    data_memory_unit dut (
        .clock     (clock),
        .reset     (reset),
        .m_data    (m_data),
        .pipe_hold (pipe_hold),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready)
`ifdef DMEM_FAULT_EN
        ,
        .fault     (fault)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;
    bit check_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h, expected %h", nm, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit   [31:0] m_mem [int];
    logic [7:0]  q_tx [$];
    logic [7:0]  q_rx [$];
    bit          m_wait;      // a RAM load has had its stall cycle and is being answered
    logic [31:0] m_load_val;
    bit          m_fault;

    function automatic bit m_oor(input logic [31:0] a);
`ifdef DMEM_FAULT_EN
        return (a[30:16] != 15'd0);
`else
        return 1'b0;
`endif
    endfunction

    function automatic int m_idx(input logic [31:0] a);
        return int'(a & 32'h0000FFFF);
    endfunction

    always @(negedge clock) begin
        logic        e, w, mm;
        logic [1:0]  off;
        logic [31:0] a;
        logic        exp_stall;
        logic [31:0] exp_rd;
        bit          do_tx_pop, do_tx_push, do_rx_pop, do_rx_push;
        if (check_en) begin
            e   = m_data.en;
            w   = m_data.we;
            a   = m_data.addr;
            mm  = a[31];
            off = a[1:0];

            exp_stall = 1'b0;
            if (e && !w && !mm)                   exp_stall = !m_wait;
            else if (e && w && mm && off == 2'd0) exp_stall = (q_tx.size() == 16);

            exp_rd = 32'h0;
            if (e && !w) begin
                if (!mm) begin
                    if (m_wait) exp_rd = m_load_val;
                end else if (off == 2'd1) begin
                    if (q_rx.size() != 0) exp_rd = {24'h0, q_rx[0]};
                end else if (off == 2'd2) begin
                    exp_rd = {30'h0, q_rx.size() != 0, q_tx.size() < 16};
                end
            end

            chk("m_stall", {31'h0, m_data.stall}, {31'h0, exp_stall});
            if (!e || !w) chk("m_rd", m_data.rd, exp_rd);
            chk("m_tx_valid", {31'h0, tx_valid}, {31'h0, q_tx.size() != 0});
            if (q_tx.size() != 0) chk("m_tx_data", {24'h0, tx_data}, {24'h0, q_tx[0]});
            chk("m_rx_ready", {31'h0, rx_ready}, {31'h0, q_rx.size() < 16});
`ifdef DMEM_FAULT_EN
            chk("m_fault", {31'h0, fault}, {31'h0, m_fault});
`endif

            if (reset) begin
                q_tx.delete();
                q_rx.delete();
                m_wait  = 1'b0;
                m_fault = 1'b0;
            end else begin
                do_tx_pop  = (q_tx.size() != 0) && tx_ready;
                do_tx_push = e && w && mm && off == 2'd0 && q_tx.size() < 16 && !pipe_hold;
                do_rx_pop  = e && !w && mm && off == 2'd1 && q_rx.size() != 0 && !pipe_hold;
                do_rx_push = rx_valid && q_rx.size() < 16;

                if (e && w && !mm && !pipe_hold) begin
                    if (m_oor(a)) m_fault = 1'b1;
                    else          m_mem[m_idx(a)] = m_data.wd;
                end

                if (m_wait) begin
                    if (!pipe_hold) begin
                        m_wait = 1'b0;
                        if (e && !w && !mm && m_oor(a)) m_fault = 1'b1;
                    end
                end else if (e && !w && !mm) begin
                    m_wait     = 1'b1;
                    m_load_val = m_oor(a) ? 32'hDEADBEEF : m_mem[m_idx(a)];
                end

                if (do_tx_pop)  void'(q_tx.pop_front());
                if (do_tx_push) q_tx.push_back(m_data.wd[7:0]);
                if (do_rx_pop)  void'(q_rx.pop_front());
                if (do_rx_push) q_rx.push_back(rx_data);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic req(input logic e, input logic w, input logic [31:0] a, input logic [31:0] d);
        m_data.en   = e;
        m_data.we   = w;
        m_data.addr = a;
        m_data.wd   = d;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset     = 1'b1;
        pipe_hold = 1'b0;
        tx_ready  = 1'b0;
        rx_valid  = 1'b0;
        rx_data   = 8'h00;
        req(1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        check_en = 1'b1;
        tick();
        reset = 1'b0;

        // post-reset idle outputs
        @(negedge clock);
        chk("rst_stall", {31'h0, m_data.stall}, 32'h0);
        chk("rst_rd", m_data.rd, 32'h0);
        chk("rst_tx_valid", {31'h0, tx_valid}, 32'h0);
        chk("rst_rx_ready", {31'h0, rx_ready}, 32'h1);
        tick();

        // store then load addr 5
        req(1'b1, 1'b1, 32'd5, 32'h12345678);
        @(negedge clock); chk("st_nostall", {31'h0, m_data.stall}, 32'h0);
        tick();
        req(1'b1, 1'b0, 32'd5, 32'h0);
        @(negedge clock);
        chk("ld_stall", {31'h0, m_data.stall}, 32'h1);
        chk("ld_rd_stallcyc", m_data.rd, 32'h0);
        tick();
        @(negedge clock);
        chk("ld_wait_stall", {31'h0, m_data.stall}, 32'h0);
        chk("ld_rd", m_data.rd, 32'h12345678);
        tick();
        req(1'b0, 1'b0, 32'h0, 32'h0);
        tick();

        // load held in LOAD_WAIT for 3 cycles
        req(1'b1, 1'b0, 32'd5, 32'h0);
        tick();
        pipe_hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            chk("hold_rd", m_data.rd, 32'h12345678);
            chk("hold_stall", {31'h0, m_data.stall}, 32'h0);
            tick();
        end
        pipe_hold = 1'b0;
        @(negedge clock); chk("hold_release_rd", m_data.rd, 32'h12345678);
        tick();
        @(negedge clock); chk("reissue_stall", {31'h0, m_data.stall}, 32'h1);
        tick();
        tick();
        req(1'b0, 1'b0, 32'h0, 32'h0);
        tick();

        // TX fill to full, 17th store stalls until a pop frees a slot
        for (int i = 0; i < 16; i++) begin
            req(1'b1, 1'b1, 32'h80000000, 32'hA0 + i);
            @(negedge clock); chk("tx_fill_nostall", {31'h0, m_data.stall}, 32'h0);
            tick();
        end
        req(1'b1, 1'b1, 32'h80000000, 32'hB0);
        @(negedge clock); chk("tx_full_stall", {31'h0, m_data.stall}, 32'h1);
        tick();
        tx_ready = 1'b1;
        @(negedge clock);
        chk("tx_full_stall_pop", {31'h0, m_data.stall}, 32'h1);
        chk("tx_head", {24'h0, tx_data}, 32'hA0);
        tick();
        tx_ready = 1'b0;
        @(negedge clock); chk("tx_after_pop_nostall", {31'h0, m_data.stall}, 32'h0);
        tick();
        req(1'b0, 1'b0, 32'h0, 32'h0);
        tx_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            @(negedge clock); chk("tx_drain", {24'h0, tx_data}, 32'hA1 + i);
            tick();
        end
        tx_ready = 1'b0;
        @(negedge clock); chk("tx_drained", {31'h0, tx_valid}, 32'h0);
        tick();

        // RX bytes, status read, pop-once under pipe_hold
        rx_valid = 1'b1;
        rx_data  = 8'h55;
        tick();
        rx_data  = 8'h66;
        tick();
        rx_valid = 1'b0;
        req(1'b1, 1'b0, 32'h80000002, 32'h0);
        @(negedge clock); chk("status_two", m_data.rd, 32'h3);
        tick();
        req(1'b1, 1'b0, 32'h80000001, 32'h0);
        @(negedge clock); chk("rx_first", m_data.rd, 32'h55);
        tick();
        pipe_hold = 1'b1;
        @(negedge clock); chk("rx_second_held", m_data.rd, 32'h66);
        tick();
        pipe_hold = 1'b0;
        @(negedge clock); chk("rx_second_replay", m_data.rd, 32'h66);
        tick();
        req(1'b1, 1'b0, 32'h80000002, 32'h0);
        @(negedge clock); chk("status_empty", m_data.rd, 32'h1);
        tick();

        // RX fill to full, overflow byte refused, then drain in order
        req(1'b0, 1'b0, 32'h0, 32'h0);
        rx_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            rx_data = 8'(i);
            tick();
        end
        rx_data = 8'hEE;
        @(negedge clock); chk("rx_full_ready", {31'h0, rx_ready}, 32'h0);
        tick();
        rx_valid = 1'b0;
        for (int i = 0; i < 16; i++) begin
            req(1'b1, 1'b0, 32'h80000001, 32'h0);
            @(negedge clock); chk("rx_drain", m_data.rd, i);
            tick();
        end
        @(negedge clock); chk("rx_empty_rd", m_data.rd, 32'h0);
        tick();
        req(1'b1, 1'b0, 32'h80000003, 32'h0);
        @(negedge clock); chk("reserved_rd", m_data.rd, 32'h0);
        tick();

        // reset during LOAD_WAIT with 3 TX bytes queued
        for (int i = 0; i < 3; i++) begin
            req(1'b1, 1'b1, 32'h80000000, 32'h10 + i);
            tick();
        end
        req(1'b1, 1'b0, 32'd5, 32'h0);
        tick();
        reset = 1'b1;
        @(negedge clock); chk("pre_reset_rd", m_data.rd, 32'h12345678);
        tick();
        reset = 1'b0;
        req(1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clock);
        chk("midrst_stall", {31'h0, m_data.stall}, 32'h0);
        chk("midrst_rd", m_data.rd, 32'h0);
        chk("midrst_tx_valid", {31'h0, tx_valid}, 32'h0);
        chk("midrst_rx_ready", {31'h0, rx_ready}, 32'h1);
        tick();
        req(1'b1, 1'b0, 32'd5, 32'h0);
        tick();
        @(negedge clock); chk("ram_retained", m_data.rd, 32'h12345678);
        tick();

        // store above the RAM index range: wraps by default, dropped with fault trapping
        req(1'b1, 1'b1, 32'h00010005, 32'hCAFEF00D);
        tick();
        req(1'b1, 1'b0, 32'd5, 32'h0);
        tick();
`ifdef DMEM_FAULT_EN
        @(negedge clock); chk("oor_store_dropped", m_data.rd, 32'h12345678);
`else
        @(negedge clock); chk("wrap_store", m_data.rd, 32'hCAFEF00D);
`endif
        tick();
        req(1'b0, 1'b0, 32'h0, 32'h0);
        tick();

`ifdef DMEM_FAULT_EN
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clock); chk("fault_cleared", {31'h0, fault}, 32'h0);
        tick();
        req(1'b1, 1'b0, 32'h00010000, 32'h0);
        @(negedge clock); chk("oor_ld_stall", {31'h0, m_data.stall}, 32'h1);
        tick();
        @(negedge clock);
        chk("oor_ld_rd", m_data.rd, 32'hDEADBEEF);
        chk("oor_ld_nostall", {31'h0, m_data.stall}, 32'h0);
        tick();
        req(1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clock); chk("fault_set", {31'h0, fault}, 32'h1);
        tick();
        tick();
        @(negedge clock); chk("fault_sticky", {31'h0, fault}, 32'h1);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clock); chk("fault_reset", {31'h0, fault}, 32'h0);
        tick();
`endif

        tick();
        check_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/data_memory_unit.md
Name: data_memory_unit

Overview:
- Data-side memory slave that serves the EX/MEM stage's data port (DataMemory.slave modport, instance name m_data).
- Backs word-addressed data RAM with a 1-cycle synchronous-read block RAM and inserts a load stall while the RAM responds.
- Maps a small MMIO window (addr[31]=1) onto byte TX/RX FIFOs for the serial link.
- Commits side effects only when the pipeline actually advances.

Parameters:
- DEPTH_LOG2, 16: data RAM holds 2^DEPTH_LOG2 32-bit words.
- TX_FIFO_LOG2, 4: TX FIFO depth is 2^TX_FIFO_LOG2 bytes.
- RX_FIFO_LOG2, 4: RX FIFO depth is 2^RX_FIFO_LOG2 bytes.

Ports:
- clock  in  1  system clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high.
- en  in  1  m_data.en: an access is requested.
- we  in  1  m_data.we: 1 = store, 0 = load.
- addr  in  32  m_data.addr: word address.
- wd  in  32  m_data.wd: store data.
- pipe_hold  in  1  instruction-side stall. When 1, the current request is replayed next cycle and must not commit.
- stall  out  1  m_data.stall, combinational. When 1, the master holds en/we/addr/wd stable.
- rd  out  32  m_data.rd: load data, valid in the cycle stall=0.
- tx_data  out  8  head byte of the TX FIFO.
- tx_valid  out  1  TX FIFO non-empty.
- tx_ready  in  1  consumer accepts tx_data on an edge when tx_valid=1.
- rx_data  in  8  incoming byte.
- rx_valid  in  1  incoming byte present.
- rx_ready  out  1  RX FIFO not full; a byte is pushed on an edge when rx_valid & rx_ready.

Behaviour:
- Interface: reset is synchronous, active-high and named reset; the clock is named clock.
- Address decode:
  - addr[31]=0: RAM, index addr[DEPTH_LOG2-1:0]; bits 30..DEPTH_LOG2 are ignored (address wraps).
  - addr[31]=1: MMIO, offset addr[1:0].
    - 0 = TX data.
    - 1 = RX data.
    - 2 = status {30'b0, rx_nonempty, tx_notfull}.
    - 3 = reserved: reads 0, writes ignored.
- FSM states: IDLE, LOAD_WAIT.
- RAM load:
  - In IDLE with en & ~we & ~addr[31]: stall=1, issue the RAM read, go to LOAD_WAIT.
  - In LOAD_WAIT: stall=0, rd = RAM output.
  - Leave for IDLE when pipe_hold=0; stay while pipe_hold=1, with the RAM output register held so rd stays valid.
  - Latency is exactly 1 stall cycle per load.
- RAM store: no stall. Word written on the edge where en & we & ~addr[31] & ~pipe_hold.
- MMIO loads: combinational, no stall.
  - RX data: rd = {24'b0, RX head}. Pop on the edge where en & ~we & ~stall & ~pipe_hold.
  - RX empty: rd=0, no pop.
  - Status: rd is taken from FIFO state at the start of the cycle.
- MMIO TX store:
  - stall=1 while the TX FIFO is full. Fullness is sampled from registered state; there is no same-cycle pop bypass.
  - When not full and pipe_hold=0, push wd[7:0] on the edge.
- FIFOs:
  - Circular, with pointer wrap modulo depth. Full/empty are derived from an occupancy counter of width LOG2+1.
  - A simultaneous push and pop on a non-full, non-empty FIFO leaves the count unchanged.
- rd=0 whenever en=0, or in IDLE on a RAM load (the stall cycle).
- Reset, including mid-load:
  - State returns to IDLE and both FIFOs are emptied.
  - Outputs: stall=0, rd=0, tx_valid=0, rx_ready=1 from the first post-reset cycle.
  - RAM contents are not cleared.

Optional Feature:
- Macro: DMEM_FAULT_EN.
- Defined:
  - A RAM access with any of addr[30:DEPTH_LOG2] nonzero is out of range.
  - Out-of-range stores are dropped.
  - Out-of-range loads still take the 1 stall cycle and return 32'hDEADBEEF.
  - An extra output port fault (1 bit) is set sticky on the committing edge and is cleared only by reset.
- Undefined: addresses wrap as described above, and there is no fault port.

Test Plan:
- Store 32'h12345678 to addr 5, then load addr 5 -> store causes no stall; load gives stall=1 for 1 cycle, then rd=32'h12345678 with stall=0.
- Load addr 5 with pipe_hold=1 for 3 cycles in LOAD_WAIT -> rd stays 32'h12345678 each cycle; FSM returns to IDLE only when pipe_hold drops.
- 17 stores of 8'hA0+i to 32'h80000000 with tx_ready=0, depth 16 -> first 16 accepted; 17th holds stall=1 until tx_ready=1 pops one, then pushes; tx_data order is A0..B0.
- Drive rx bytes 8'h55, 8'h66; load 32'h80000002 then 32'h80000001 twice, the second read repeated under pipe_hold=1 -> status=2'b10|tx bit; reads return 55 then 66, and only one pop per read.
- Reset asserted during LOAD_WAIT with 3 bytes in TX -> next cycle stall=0, rd=0, tx_valid=0, rx_ready=1; RAM word at addr 5 is retained.
- DMEM_FAULT_EN defined, DEPTH_LOG2=16, load addr 32'h00010000 -> 1 stall cycle, rd=32'hDEADBEEF, fault=1 until reset.
